exec_op_controller: RTL and testbench

//  Execute-stage operation controller: decodes ALUOp/Funct3/Funct7 into an OP_W-bit ALU operation code
//  (RV32I incl. unsigned compares) and sequences multi-cycle RV32M MUL/DIV ops through an FSM + counter.

---
 rtl/exec_pkg.sv | 50 +++++
 rtl/alu_op_decode.sv | 73 +++++++
 rtl/exec_op_controller.sv | 118 +++++++++++
 tb/tb_exec_op_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg
//   Shared definitions for the execute-stage operation controller:
//   ALU operation codes, ALUOp class constants, Funct7 patterns and the
//   mul/div sequencer state type.
//   No ports (package).
package exec_pkg;

  // Base 5-bit ALU operation codes; wider Operation buses zero-extend these.
  typedef enum logic [4:0] {
    OP_AND   = 5'b00000,
    OP_OR    = 5'b00001,
    OP_ADD   = 5'b00010,
    OP_XOR   = 5'b00011,
    OP_SLL   = 5'b00100,
    OP_SRL   = 5'b00101,
    OP_SUB   = 5'b00110,
    OP_SRA   = 5'b00111,
    OP_BEQ   = 5'b01000,
    OP_BLT   = 5'b01001,
    OP_BGE   = 5'b01010,
    OP_BNE   = 5'b01011,
    OP_SLT   = 5'b01100,
    OP_PASSB = 5'b01101,
    OP_SLTU  = 5'b01110,
    OP_BLTU  = 5'b01111,
    OP_BGEU  = 5'b10000
  } alu_op_e;

  // M-extension ops are encoded as {M_OP_PREFIX, Funct3}.
  localparam logic [1:0] M_OP_PREFIX = 2'b11;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;
  localparam logic [6:0] FUNCT7_M   = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode
//   Combinational decode of ALUOp/Funct7/Funct3 into an ALU operation code.
//   Ports:
//     alu_op_i   in   2     instruction class from the main decoder
//     funct7_i   in   7     instr[31:25]
//     funct3_i   in   3     instr[14:12]
//     op_o       out  OP_W  operation code (ADD when undecodable)
//     bad_o      out  1     encoding not decodable (not qualified by valid)
//     is_m_o     out  1     encoding is an enabled RV32M op
module alu_op_decode
  import exec_pkg::*;
#(
  parameter int OP_W     = 5,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [1:0]      alu_op_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  output logic [OP_W-1:0] op_o,
  output logic            bad_o,
  output logic            is_m_o
);

  logic [4:0] op5;

  // Funct7 is only consulted for ADD/SUB, SRL/SRA and the M-extension
  // marker, because I-type immediates reuse those bits.
  always_comb begin
    op5    = OP_ADD;
    bad_o  = 1'b0;
    is_m_o = 1'b0;
    case (alu_op_i)
      ALUOP_MEM:  op5 = OP_ADD;
      ALUOP_JUMP: op5 = OP_PASSB;
      ALUOP_BRANCH: begin
        case (funct3_i)
          3'b000:  op5 = OP_BEQ;
          3'b001:  op5 = OP_BNE;
          3'b100:  op5 = OP_BLT;
          3'b101:  op5 = OP_BGE;
          3'b110:  op5 = OP_BLTU;
          3'b111:  op5 = OP_BGEU;
          default: bad_o = 1'b1;
        endcase
      end
      ALUOP_RTYPE: begin
        if (funct7_i == FUNCT7_M) begin
          if (ENABLE_M) begin
            op5    = {M_OP_PREFIX, funct3_i};
            is_m_o = 1'b1;
          end else begin
            bad_o = 1'b1;
          end
        end else begin
          case (funct3_i)
            3'b000:  op5 = (funct7_i == FUNCT7_ALT) ? OP_SUB : OP_ADD;
            3'b001:  op5 = OP_SLL;
            3'b010:  op5 = OP_SLT;
            3'b011:  op5 = OP_SLTU;
            3'b100:  op5 = OP_XOR;
            3'b101:  op5 = (funct7_i == FUNCT7_ALT) ? OP_SRA : OP_SRL;
            3'b110:  op5 = OP_OR;
            default: op5 = OP_AND;
          endcase
        end
      end
      default: op5 = OP_ADD;
    endcase
  end

  assign op_o = OP_W'(op5);

endmodule

// File: rtl/exec_op_controller.sv
// exec_op_controller
//   Execute-stage operation controller: ALU op decode plus a small FSM that
//   sequences multi-cycle RV32M mul/div operations and stalls the pipeline.
//   Ports:
//     clk, reset            clock (rising edge), async active-high reset
//     in_valid, flush       ID/EX holds an instruction / squash it
//     ALUOp, Funct7, Funct3 instruction decode fields
//     Operation, illegal    combinational ALU op code / undecodable flag
//     md_start, md_done     one-cycle launch / result-valid pulses
//     md_abort              one-cycle pulse when an in-flight op is squashed
//     md_op                 registered Funct3 of the accepted M op
//     stall, busy           pipeline freeze / sequencer not idle
module exec_op_controller
  import exec_pkg::*;
#(
  parameter int OP_W       = 5,
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  output logic [OP_W-1:0] Operation,
  output logic            illegal,
  output logic            md_start,
  output logic [2:0]      md_op,
  output logic            md_done,
  output logic            md_abort,
  output logic            stall,
  output logic            busy
);

  localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       md_op_q, md_op_d;
  logic             dec_bad;
  logic             dec_is_m;

  alu_op_decode #(
    .OP_W     (OP_W),
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .alu_op_i (ALUOp),
    .funct7_i (Funct7),
    .funct3_i (Funct3),
    .op_o     (Operation),
    .bad_o    (dec_bad),
    .is_m_o   (dec_is_m)
  );

  assign illegal = in_valid & dec_bad;
  assign md_op   = md_op_q;
  assign busy    = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      md_op_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_op_q <= md_op_d;
    end
  end

  // The accept in IDLE is gated by reset so the launch strobe and stall
  // drop the moment reset rises, not just at the next edge. Funct3[2]
  // separates the divide family from the multiply family.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_op_d  = md_op_q;
    md_start = 1'b0;
    md_done  = 1'b0;
    md_abort = 1'b0;
    stall    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && dec_is_m && !flush && !reset) begin
          md_start = 1'b1;
          stall    = 1'b1;
          md_op_d  = Funct3;
          cnt_d    = Funct3[2] ? DIV_LOAD : MUL_LOAD;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          md_abort = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          stall = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        md_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exec_op_controller.sv
// tb_exec_op_controller
//   Randomized self-checking bench for exec_op_controller. A second instance
//   with the M extension disabled shares the input stimulus.
module tb_exec_op_controller;

  localparam int MUL_N = 4;
  localparam int DIV_N = 33;
  localparam logic [6:0] F7_M   = 7'b0000001;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       flush;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;

  logic [4:0] Operation, Operation2;
  logic       illegal, illegal2;
  logic       md_start, md_start2;
  logic [2:0] md_op, md_op2;
  logic       md_done, md_done2;
  logic       md_abort, md_abort2;
  logic       stall, stall2;
  logic       busy, busy2;

  int nTotal = 0;
  int nBad   = 0;

  always #5 clk = ~clk;

  exec_op_controller #(
    .OP_W(5), .ENABLE_M(1'b1), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .Operation(Operation), .illegal(illegal), .md_start(md_start),
    .md_op(md_op), .md_done(md_done), .md_abort(md_abort),
    .stall(stall), .busy(busy)
  );

  exec_op_controller #(
    .OP_W(5), .ENABLE_M(1'b0), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)
  ) dut_nom (
    .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .Operation(Operation2), .illegal(illegal2), .md_start(md_start2),
    .md_op(md_op2), .md_done(md_done2), .md_abort(md_abort2),
    .stall(stall2), .busy(busy2)
  );

  // Control strobes packed as {start, done, abort, stall, busy}.
  function automatic logic [4:0] ctrl1();
    return {md_start, md_done, md_abort, stall, busy};
  endfunction

  function automatic logic [4:0] ctrl2();
    return {md_start2, md_done2, md_abort2, stall2, busy2};
  endfunction

  // Reference decode written as lookup tables indexed by Funct3.
  function automatic void ref_decode(input logic [1:0] aop, input logic [6:0] f7,
                                     input logic [2:0] f3, input bit en_m,
                                     output logic [4:0] code, output bit bad);
    int rmap[8];
    int bmap[8];
    int c;
    rmap = '{2, 4, 12, 14, 3, 5, 1, 0};
    bmap = '{8, 11, -1, -1, 9, 10, 15, 16};
    bad = 1'b0;
    c = 2;
    case (aop)
      2'd0: c = 2;
      2'd3: c = 13;
      2'd1: begin
        c = bmap[f3];
        if (c < 0) begin
          bad = 1'b1;
          c = 2;
        end
      end
      default: begin
        if (f7 == F7_M) begin
          if (en_m) c = 24 + int'(f3);
          else bad = 1'b1;
        end else if (f7 == F7_ALT && f3 == 3'd0) c = 6;
        else if (f7 == F7_ALT && f3 == 3'd5) c = 7;
        else c = rmap[f3];
      end
    endcase
    code = 5'(c);
  endfunction

  task automatic applyStimulus(input logic v, input logic [1:0] aop,
                               input logic [6:0] f7, input logic [2:0] f3,
                               input logic fl);
    in_valid = v;
    ALUOp    = aop;
    Funct7   = f7;
    Funct3   = f3;
    flush    = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 2'b10, F7_M, 3'b000, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nTotal++;
    if (ctrl1() !== 5'b00000) begin
      nBad++;
      $display("[TB] FAIL reset_ctrl got=%b want=00000", ctrl1());
    end
    nTotal++;
    if (md_op !== 3'b000) begin
      nBad++;
      $display("[TB] FAIL reset_md_op got=%b want=000", md_op);
    end
    applyStimulus(1'b0, 2'b00, 7'd0, 3'd0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_directed_decode();
    logic [1:0] aops[6];
    logic [6:0] f7s[6];
    logic [2:0] f3s[6];
    logic [4:0] wantOp[6];
    logic       wantIll[6];
    aops    = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11};
    f7s     = '{F7_ALT, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
    f3s     = '{3'b000, 3'b011, 3'b111, 3'b010, 3'b101, 3'b001};
    wantOp  = '{5'b00110, 5'b01110, 5'b10000, 5'b00010, 5'b00010, 5'b01101};
    wantIll = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, aops[i], f7s[i], f3s[i], 1'b0);
      @(negedge clk);
      nTotal++;
      if (Operation !== wantOp[i] || illegal !== wantIll[i] || stall !== 1'b0) begin
        nBad++;
        $display("[TB] FAIL directed_%0d got op=%b ill=%b stall=%b want op=%b ill=%b stall=0",
                 i, Operation, illegal, stall, wantOp[i], wantIll[i]);
      end
      next_cycle();
    end
  endtask

  // flush held high keeps the sequencer idle so pure decode can be checked.
  task automatic test_decode_random();
    logic [6:0] f7;
    logic [4:0] eOp, eOp2;
    bit         eBad, eBad2;
    logic       v;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: f7 = 7'd0;
        1: f7 = F7_ALT;
        2: f7 = F7_M;
        default: f7 = 7'($urandom);
      endcase
      v = 1'($urandom);
      applyStimulus(v, 2'($urandom), f7, 3'($urandom), 1'b1);
      ref_decode(ALUOp, Funct7, Funct3, 1'b1, eOp, eBad);
      ref_decode(ALUOp, Funct7, Funct3, 1'b0, eOp2, eBad2);
      @(negedge clk);
      nTotal++;
      if (Operation !== eOp || illegal !== (v & eBad) || ctrl1() !== 5'b00000) begin
        nBad++;
        $display("[TB] FAIL rand_decode aop=%b f7=%b f3=%b got op=%b ill=%b ctrl=%b want op=%b ill=%b ctrl=00000",
                 ALUOp, Funct7, Funct3, Operation, illegal, ctrl1(), eOp, v & eBad);
      end
      nTotal++;
      if (Operation2 !== eOp2 || illegal2 !== (v & eBad2)) begin
        nBad++;
        $display("[TB] FAIL rand_decode_nom aop=%b f7=%b f3=%b got op=%b ill=%b want op=%b ill=%b",
                 ALUOp, Funct7, Funct3, Operation2, illegal2, eOp2, v & eBad2);
      end
      next_cycle();
    end
    applyStimulus(1'b0, 2'b00, 7'd0, 3'd0, 1'b0);
  endtask

  // Back-to-back M ops: the next op is presented in the cycle right after DONE.
  task automatic test_m_ops();
    logic [2:0] ops[8];
    logic [4:0] want;
    int n;
    ops[0] = 3'b000;
    ops[1] = 3'b101;
    ops[2] = 3'b000;
    for (int j = 3; j < 8; j++) ops[j] = 3'($urandom);
    for (int j = 0; j < 8; j++) begin
      n = ops[j][2] ? DIV_N : MUL_N;
      for (int k = 0; k <= n + 1; k++) begin
        applyStimulus(1'b1, 2'b10, F7_M, ops[j], 1'b0);
        @(negedge clk);
        want = {k == 0, k == n + 1, 1'b0, k <= n, k > 0};
        nTotal++;
        if (ctrl1() !== want) begin
          nBad++;
          $display("[TB] FAIL mop_seq op=%0d f3=%b k=%0d got ctrl=%b want ctrl=%b",
                   j, ops[j], k, ctrl1(), want);
        end
        if (k == 1 || k == n + 1) begin
          nTotal++;
          if (md_op !== ops[j] || Operation !== {2'b11, ops[j]}) begin
            nBad++;
            $display("[TB] FAIL mop_md_op k=%0d got md_op=%b op=%b want md_op=%b op=%b",
                     k, md_op, Operation, ops[j], {2'b11, ops[j]});
          end
        end
        next_cycle();
      end
    end
    applyStimulus(1'b1, 2'b00, 7'd0, 3'd0, 1'b0);
    @(negedge clk);
    nTotal++;
    if (ctrl1() !== 5'b00000) begin
      nBad++;
      $display("[TB] FAIL mop_base_after got ctrl=%b want ctrl=00000", ctrl1());
    end
    next_cycle();
  endtask

  task automatic test_flush();
    logic [2:0] f3;
    logic [4:0] want;
    int n, at;
    for (int r = 0; r < 4; r++) begin
      f3 = (r == 0) ? 3'b100 : 3'($urandom);
      n  = f3[2] ? DIV_N : MUL_N;
      at = (r == 0) ? 3 : $urandom_range(1, n);
      for (int k = 0; k <= at; k++) begin
        applyStimulus(1'b1, 2'b10, F7_M, f3, k == at);
        @(negedge clk);
        if (k == at) want = 5'b00101;
        else want = {k == 0, 1'b0, 1'b0, 1'b1, k > 0};
        nTotal++;
        if (ctrl1() !== want) begin
          nBad++;
          $display("[TB] FAIL flush_run f3=%b at=%0d k=%0d got ctrl=%b want ctrl=%b",
                   f3, at, k, ctrl1(), want);
        end
        next_cycle();
      end
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1'b0, 2'b00, 7'd0, 3'd0, 1'b0);
        @(negedge clk);
        nTotal++;
        if (ctrl1() !== 5'b00000) begin
          nBad++;
          $display("[TB] FAIL flush_after k=%0d got ctrl=%b want ctrl=00000", k, ctrl1());
        end
        next_cycle();
      end
    end
    // flush while idle: nothing is accepted
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 2'b10, F7_M, 3'b001, 1'b1);
      @(negedge clk);
      nTotal++;
      if (ctrl1() !== 5'b00000) begin
        nBad++;
        $display("[TB] FAIL flush_idle k=%0d got ctrl=%b want ctrl=00000", k, ctrl1());
      end
      next_cycle();
    end
    // flush during DONE is ignored
    for (int k = 0; k <= MUL_N + 1; k++) begin
      applyStimulus(1'b1, 2'b10, F7_M, 3'b011, k == MUL_N + 1);
      @(negedge clk);
      want = {k == 0, k == MUL_N + 1, 1'b0, k <= MUL_N, k > 0};
      nTotal++;
      if (ctrl1() !== want) begin
        nBad++;
        $display("[TB] FAIL flush_done k=%0d got ctrl=%b want ctrl=%b", k, ctrl1(), want);
      end
      next_cycle();
    end
    applyStimulus(1'b0, 2'b00, 7'd0, 3'd0, 1'b0);
    @(negedge clk);
    nTotal++;
    if (ctrl1() !== 5'b00000) begin
      nBad++;
      $display("[TB] FAIL flush_done_after got ctrl=%b want ctrl=00000", ctrl1());
    end
    next_cycle();
  endtask

  task automatic test_reset_midrun();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 2'b10, F7_M, 3'b110, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    nTotal++;
    if (stall !== 1'b1 || busy !== 1'b1) begin
      nBad++;
      $display("[TB] FAIL midrun_pre got stall=%b busy=%b want stall=1 busy=1", stall, busy);
    end
    #1;
    reset = 1'b1;
    #1;
    nTotal++;
    if (ctrl1() !== 5'b00000 || md_op !== 3'b000) begin
      nBad++;
      $display("[TB] FAIL midrun_reset got ctrl=%b md_op=%b want ctrl=00000 md_op=000",
               ctrl1(), md_op);
    end
    applyStimulus(1'b0, 2'b00, 7'd0, 3'd0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_disable_m();
    for (int k = 0; k <= MUL_N + 1; k++) begin
      applyStimulus(1'b1, 2'b10, F7_M, 3'b000, 1'b0);
      @(negedge clk);
      nTotal++;
      if (illegal2 !== 1'b1 || Operation2 !== 5'b00010 || ctrl2() !== 5'b00000) begin
        nBad++;
        $display("[TB] FAIL nom_mul k=%0d got ill=%b op=%b ctrl=%b want ill=1 op=00010 ctrl=00000",
                 k, illegal2, Operation2, ctrl2());
      end
      next_cycle();
    end
    applyStimulus(1'b0, 2'b00, 7'd0, 3'd0, 1'b0);
    next_cycle();
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 2'b00, 7'd0, 3'd0, 1'b0);
    #1;
    test_reset();
    test_directed_decode();
    test_decode_random();
    test_m_ops();
    test_flush();
    test_reset_midrun();
    test_disable_m();
    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
